// File: rtl/ms_boot_seq.sv
// ---------------------------------------------------------------------------
// ms_boot_seq
// Boot sequencer. It waits for the reset/supply unit, optionally kicks the
// firmware loader and waits for it to go idle, then releases and starts each
// CPU core in turn over the debug bus. Both wait phases have optional
// timeouts that park the sequencer in an error state until it is restarted.
//
// Ports
//   AClkH         in   1  clock, rising edge
//   AResetHN      in   1  asynchronous active-low reset
//   AClkHEn       in   1  clock enable, all registers gated by it
//   ARsuReady     in   1  reset/supply unit ready
//   ALoadFW       in   1  firmware-load request (sampled every enabled cycle)
//   ALdrActive    in   1  loader busy
//   ARestart      in   1  rerun the sequence from Ready or Error
//   ADbioAddr     out 12  debug-bus address
//   ADbioMosi     out 64  debug-bus write data
//   ADbioMosiIdx  out  4  write length index (0 = no command)
//   ADbioMisoIdx  out  4  read length index, tied 0
//   ADbioMosi1st  out  1  tied 0
//   ADbioMiso1st  out  1  tied 0
//   AReady        out  1  sequence complete
//   AError        out  1  sequence aborted by timeout
//   AErrCode      out  2  01 RSU timeout, 10 loader timeout
//   ACoreIdx      out  4  core currently being started
//   ATest         out  8  {FLoadFW, AError, state code[5:0]}
//
// state     | meaning
// ----------+-------------------------------------------------------------
// Start     | idle after reset/restart, clears core index (code 0)
// RsuWait   | waiting for ARsuReady, timeout counter running (code 1)
// RsuReady  | RSU up, choose loader or cores from FLoadFW (code 2)
// LdrStart  | one loader start command on the bus (code 3)
// LdrWait   | waiting for loader idle, timeout counter running (code 4)
// CoreRst   | reset command to current core (code 5)
// CoreRun   | run command to current core, then next core or Ready (code 6)
// Ready     | done, holds until ARestart (code 7)
// Error     | timed out, holds until ARestart (code 8)
// ---------------------------------------------------------------------------
module ms_boot_seq #(
  parameter int          CCoreCnt   = 1,
  parameter logic [11:0] CCpuBase   = 12'h000,
  parameter logic [11:0] CCpuStride = 12'h010,
  parameter logic [11:0] CLdrAddr   = 12'h100,
  parameter int          CRsuTmo    = 1024,
  parameter int          CLdrTmo    = 65536
) (
  input  logic        AClkH,
  input  logic        AResetHN,
  input  logic        AClkHEn,
  input  logic        ARsuReady,
  input  logic        ALoadFW,
  input  logic        ALdrActive,
  input  logic        ARestart,
  output logic [11:0] ADbioAddr,
  output logic [63:0] ADbioMosi,
  output logic [3:0]  ADbioMosiIdx,
  output logic [3:0]  ADbioMisoIdx,
  output logic        ADbioMosi1st,
  output logic        ADbioMiso1st,
  output logic        AReady,
  output logic        AError,
  output logic [1:0]  AErrCode,
  output logic [3:0]  ACoreIdx,
  output logic [7:0]  ATest
);

  localparam int CTmoMax = (CRsuTmo > CLdrTmo) ? CRsuTmo : CLdrTmo;
  localparam int CCntW   = (CTmoMax > 0) ? $clog2(CTmoMax + 1) : 1;

  // Timeout fires while the counter holds TMO-1, i.e. during the TMO-th cycle.
  localparam logic [CCntW-1:0] CRsuLast = CCntW'((CRsuTmo > 0) ? CRsuTmo - 1 : 0);
  localparam logic [CCntW-1:0] CLdrLast = CCntW'((CLdrTmo > 0) ? CLdrTmo - 1 : 0);
  localparam logic [CCntW-1:0] CCntSat  = '1;
  localparam logic [3:0]       CLastIdx = 4'(CCoreCnt - 1);

  typedef enum logic [8:0] {
    ST_START     = 9'b0_0000_0001,
    ST_RSU_WAIT  = 9'b0_0000_0010,
    ST_RSU_READY = 9'b0_0000_0100,
    ST_LDR_START = 9'b0_0000_1000,
    ST_LDR_WAIT  = 9'b0_0001_0000,
    ST_CORE_RST  = 9'b0_0010_0000,
    ST_CORE_RUN  = 9'b0_0100_0000,
    ST_READY     = 9'b0_1000_0000,
    ST_ERROR     = 9'b1_0000_0000
  } state_t;

  state_t           r_state;
  logic [CCntW-1:0] r_tmo_cnt;
  logic [3:0]       r_core_idx;
  logic             r_load_fw;
  logic [1:0]       r_err_code;

  logic [11:0]      w_core_addr;
  logic [11:0]      w_addr;
  logic [63:0]      w_mosi;
  logic [3:0]       w_mosi_idx;
  logic [5:0]       w_state_code;
  logic             w_ready;
  logic             w_error;

  // Any encoding not listed (including all-zero) falls into the default arm
  // and behaves as Start.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      r_state    <= ST_START;
      r_tmo_cnt  <= '0;
      r_core_idx <= '0;
      r_load_fw  <= 1'b0;
      r_err_code <= 2'b00;
    end else if (AClkHEn) begin
      r_load_fw <= ALoadFW;
      case (r_state)
        ST_RSU_WAIT: begin
          if (ARsuReady) begin
            r_state <= ST_RSU_READY;
          end else if ((CRsuTmo != 0) && (r_tmo_cnt == CRsuLast)) begin
            r_state    <= ST_ERROR;
            r_err_code <= 2'b01;
          end else if (r_tmo_cnt != CCntSat) begin
            r_tmo_cnt <= r_tmo_cnt + CCntW'(1);
          end
        end
        ST_RSU_READY: begin
          if (r_load_fw) r_state <= ST_LDR_START;
          else           r_state <= ST_CORE_RST;
        end
        ST_LDR_START: begin
          r_state   <= ST_LDR_WAIT;
          r_tmo_cnt <= '0;
        end
        ST_LDR_WAIT: begin
          if (!ALdrActive) begin
            r_state <= ST_CORE_RST;
          end else if ((CLdrTmo != 0) && (r_tmo_cnt == CLdrLast)) begin
            r_state    <= ST_ERROR;
            r_err_code <= 2'b10;
          end else if (r_tmo_cnt != CCntSat) begin
            r_tmo_cnt <= r_tmo_cnt + CCntW'(1);
          end
        end
        ST_CORE_RST: begin
          r_state <= ST_CORE_RUN;
        end
        ST_CORE_RUN: begin
          if (r_core_idx < CLastIdx) begin
            r_state    <= ST_CORE_RST;
            r_core_idx <= r_core_idx + 4'd1;
          end else begin
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (ARestart) begin
            r_state    <= ST_START;
            r_core_idx <= '0;
          end
        end
        ST_ERROR: begin
          if (ARestart) begin
            r_state    <= ST_START;
            r_core_idx <= '0;
            r_err_code <= 2'b00;
          end
        end
        default: begin
          r_state    <= ST_RSU_WAIT;
          r_tmo_cnt  <= '0;
          r_core_idx <= '0;
        end
      endcase
    end
  end

  // 12-bit product and sum wrap naturally.
  assign w_core_addr = CCpuBase + ({8'd0, r_core_idx} * CCpuStride);

  always_comb begin
    w_addr     = '0;
    w_mosi     = '0;
    w_mosi_idx = '0;
    case (r_state)
      ST_LDR_START: begin
        w_addr     = CLdrAddr;
        w_mosi     = 64'd1;
        w_mosi_idx = 4'd2;
      end
      ST_CORE_RST: begin
        w_addr     = w_core_addr;
        w_mosi     = 64'd3;
        w_mosi_idx = 4'd1;
      end
      ST_CORE_RUN: begin
        w_addr     = w_core_addr;
        w_mosi     = 64'd5;
        w_mosi_idx = 4'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_code = 6'd0;
    case (r_state)
      ST_RSU_WAIT:  w_state_code = 6'd1;
      ST_RSU_READY: w_state_code = 6'd2;
      ST_LDR_START: w_state_code = 6'd3;
      ST_LDR_WAIT:  w_state_code = 6'd4;
      ST_CORE_RST:  w_state_code = 6'd5;
      ST_CORE_RUN:  w_state_code = 6'd6;
      ST_READY:     w_state_code = 6'd7;
      ST_ERROR:     w_state_code = 6'd8;
      default:      w_state_code = 6'd0;
    endcase
  end

  assign w_ready = (r_state == ST_READY);
  assign w_error = (r_state == ST_ERROR);

  assign ADbioAddr    = w_addr;
  assign ADbioMosi    = w_mosi;
  assign ADbioMosiIdx = w_mosi_idx;
  assign ADbioMisoIdx = 4'd0;
  assign ADbioMosi1st = 1'b0;
  assign ADbioMiso1st = 1'b0;
  assign AReady       = w_ready;
  assign AError       = w_error;
  assign AErrCode     = r_err_code;
  assign ACoreIdx     = r_core_idx;
  assign ATest        = {r_load_fw, w_error, w_state_code};

endmodule

// File: tb/tb_ms_boot_seq.sv
module tb_ms_boot_seq;

  logic        AClkH;
  logic        AResetHN;
  logic        AClkHEn;
  logic        ARsuReady;
  logic        ALoadFW;
  logic        ALdrActive;
  logic        ARestart;
  logic [11:0] ADbioAddr;
  logic [63:0] ADbioMosi;
  logic [3:0]  ADbioMosiIdx;
  logic [3:0]  ADbioMisoIdx;
  logic        ADbioMosi1st;
  logic        ADbioMiso1st;
  logic        AReady;
  logic        AError;
  logic [1:0]  AErrCode;
  logic [3:0]  ACoreIdx;
  logic [7:0]  ATest;

  ms_boot_seq #(
    .CCoreCnt (3),
    .CRsuTmo  (8),
    .CLdrTmo  (16)
  ) u_dut (
    .AClkH        (AClkH),
    .AResetHN     (AResetHN),
    .AClkHEn      (AClkHEn),
    .ARsuReady    (ARsuReady),
    .ALoadFW      (ALoadFW),
    .ALdrActive   (ALdrActive),
    .ARestart     (ARestart),
    .ADbioAddr    (ADbioAddr),
    .ADbioMosi    (ADbioMosi),
    .ADbioMosiIdx (ADbioMosiIdx),
    .ADbioMisoIdx (ADbioMisoIdx),
    .ADbioMosi1st (ADbioMosi1st),
    .ADbioMiso1st (ADbioMiso1st),
    .AReady       (AReady),
    .AError       (AError),
    .AErrCode     (AErrCode),
    .ACoreIdx     (ACoreIdx),
    .ATest        (ATest)
  );

  initial AClkH = 1'b0;
  always #5 AClkH = ~AClkH;

  localparam logic [1:0] K_CMD   = 2'd0;
  localparam logic [1:0] K_READY = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] addr;
    logic [63:0] mosi;
    logic [3:0]  midx;
    logic [3:0]  cidx;
    logic [1:0]  ecode;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void push_cmd(input logic [11:0] a, input logic [63:0] m,
                                   input logic [3:0] mi, input logic [3:0] ci);
    exp_t e;
    e.kind = K_CMD; e.addr = a; e.mosi = m; e.midx = mi; e.cidx = ci; e.ecode = 2'b00;
    exp_q.push_back(e);
  endfunction

  function automatic void push_evt(input logic [1:0] k, input logic [1:0] ec);
    exp_t e;
    e.kind = k; e.addr = '0; e.mosi = '0; e.midx = '0; e.cidx = '0; e.ecode = ec;
    exp_q.push_back(e);
  endfunction

  // Three cores at stride 0x010, each reset (3) then run (5), then Ready.
  function automatic void push_cores_ready();
    push_cmd(12'h000, 64'd3, 4'd1, 4'd0);
    push_cmd(12'h000, 64'd5, 4'd1, 4'd0);
    push_cmd(12'h010, 64'd3, 4'd1, 4'd1);
    push_cmd(12'h010, 64'd5, 4'd1, 4'd1);
    push_cmd(12'h020, 64'd3, 4'd1, 4'd2);
    push_cmd(12'h020, 64'd5, 4'd1, 4'd2);
    push_evt(K_READY, 2'b00);
  endfunction

  // Monitor: a command is consumed when it is on the bus with the enable high;
  // Ready/Error are consumed on their rising edge.
  logic prev_ready = 1'b0;
  logic prev_error = 1'b0;

  task automatic sb_compare(input exp_t act);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected actual %h required none", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL sb_item actual %h required %h", act, e);
      end
    end
  endtask

  always @(negedge AClkH) begin
    exp_t a;
    if (AResetHN) begin
      if (AClkHEn && ADbioMosiIdx != 4'd0) begin
        a.kind = K_CMD; a.addr = ADbioAddr; a.mosi = ADbioMosi;
        a.midx = ADbioMosiIdx; a.cidx = ACoreIdx; a.ecode = AErrCode;
        sb_compare(a);
      end
      if (AReady && !prev_ready) begin
        a.kind = K_READY; a.addr = ADbioAddr; a.mosi = ADbioMosi;
        a.midx = ADbioMosiIdx; a.cidx = '0; a.ecode = AErrCode;
        sb_compare(a);
      end
      if (AError && !prev_error) begin
        a.kind = K_ERR; a.addr = ADbioAddr; a.mosi = ADbioMosi;
        a.midx = ADbioMosiIdx; a.cidx = '0; a.ecode = AErrCode;
        sb_compare(a);
      end
    end
    prev_ready = AReady;
    prev_error = AError;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge AClkH);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic wait_last_run(input string name, input int bound);
    int n;
    n = 0;
    while (!(ADbioMosi == 64'd5 && ACoreIdx == 4'd2) && n < bound) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s actual timeout required last CoreRun", name);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ADbioAddr, ADbioMosi[15:0], ADbioMosiIdx, ADbioMisoIdx, ADbioMosi1st,
                ADbioMiso1st, AReady, AError, AErrCode, ACoreIdx, ATest});
  endfunction

  initial begin
    int runs, bad, len, n;
    logic [19:0] cur, prev;

    AResetHN = 1'b0; AClkHEn = 1'b1; ARsuReady = 1'b0; ALoadFW = 1'b0;
    ALdrActive = 1'b0; ARestart = 1'b0;
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    chk("reset_mosi", ADbioMosi, 64'd0);
    tick(3);
    AResetHN = 1'b1;

    // Plain boot, three cores, RSU ready after a few cycles.
    push_cores_ready();
    tick(1);
    chk("first_edge_rsuwait", 64'(ATest), 64'h01);
    tick(2);
    ARsuReady = 1'b1;
    wait_last_run("boot_plain", 40);
    tick(1);
    chk("plain_ready", 64'(AReady), 64'd1);
    chk("plain_test_ready", 64'(ATest), 64'h07);

    // Firmware load path with restart from Ready; restart ignored in LdrWait.
    ALoadFW = 1'b1; ALdrActive = 1'b1;
    push_cmd(12'h100, 64'd1, 4'd2, 4'd0);
    push_cores_ready();
    ARestart = 1'b1; tick(1); ARestart = 1'b0;
    chk("restart_ready_clear", 64'(AReady), 64'd0);
    chk("restart_start", 64'(ATest), 64'h80);
    tick(4);
    chk("fw_ldrwait", 64'(ATest), 64'h84);
    ARestart = 1'b1; tick(1); ARestart = 1'b0;
    chk("restart_ignored", 64'(ATest), 64'h84);
    tick(3);
    ALdrActive = 1'b0;
    wait_last_run("boot_fw", 40);
    tick(1);
    chk("fw_ready", 64'(AReady), 64'd1);

    // Loader timeout on the 16th LdrWait cycle.
    ALdrActive = 1'b1;
    push_cmd(12'h100, 64'd1, 4'd2, 4'd0);
    push_evt(K_ERR, 2'b10);
    ARestart = 1'b1; tick(1); ARestart = 1'b0;
    tick(19);
    chk("ldr_tmo_before", 64'(AError), 64'd0);
    tick(1);
    chk("ldr_tmo_err", 64'(AError), 64'd1);
    chk("ldr_tmo_code", 64'(AErrCode), 64'd2);
    chk("ldr_tmo_test", 64'(ATest), 64'hC8);

    // Restart from Error, then RSU timeout on the 8th RsuWait cycle.
    ALoadFW = 1'b0; ARsuReady = 1'b0; ALdrActive = 1'b0;
    push_evt(K_ERR, 2'b01);
    ARestart = 1'b1; tick(1); ARestart = 1'b0;
    chk("err_restart_clear", 64'(AError), 64'd0);
    chk("err_restart_code", 64'(AErrCode), 64'd0);
    tick(8);
    chk("rsu_tmo_before", 64'(AError), 64'd0);
    tick(1);
    chk("rsu_tmo_err", 64'(AError), 64'd1);
    chk("rsu_tmo_code", 64'(AErrCode), 64'd1);
    chk("rsu_tmo_test", 64'(ATest), 64'h48);

    // RSU ready arrives in exactly the 8th cycle: ready wins.
    push_cores_ready();
    ARestart = 1'b1; tick(1); ARestart = 1'b0;
    chk("rsu_restart_clear", 64'({AError, AErrCode}), 64'd0);
    tick(8);
    ARsuReady = 1'b1;
    tick(1);
    chk("rsu_race_state", 64'(ATest), 64'h02);
    chk("rsu_race_noerr", 64'(AError), 64'd0);
    wait_last_run("boot_race", 40);
    tick(1);
    chk("race_ready", 64'(AReady), 64'd1);

    // Enable toggling: same commands, each held for two clocks.
    push_cores_ready();
    ARestart = 1'b1; tick(1); ARestart = 1'b0;
    runs = 0; bad = 0; len = 0; prev = '0; n = 0;
    while (!AReady && n < 200) begin
      AClkHEn = ~AClkHEn;
      tick(1);
      n++;
      cur = {ADbioAddr, ADbioMosi[3:0], ADbioMosiIdx};
      if (cur == prev) begin
        len++;
      end else begin
        if (prev[3:0] != 4'd0) begin
          runs++;
          if (len != 2) bad++;
        end
        prev = cur;
        len = 1;
      end
    end
    AClkHEn = 1'b1;
    chk("toggle_ready", 64'(AReady), 64'd1);
    chk("toggle_runs", 64'(runs), 64'd6);
    chk("toggle_hold", 64'(bad), 64'd0);

    // Reset pulse during CoreRun: outputs drop at once, then a clean boot.
    push_cmd(12'h000, 64'd3, 4'd1, 4'd0);
    ARestart = 1'b1; tick(1); ARestart = 1'b0;
    n = 0;
    while (ADbioMosi != 64'd5 && n < 20) begin
      tick(1);
      n++;
    end
    chk("reach_corerun", 64'(ADbioMosi), 64'd5);
    AResetHN = 1'b0;
    #1;
    chk("midrst_outs", all_outs(), 64'd0);
    chk("midrst_mosi", ADbioMosi, 64'd0);
    chk("midrst_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick(2);
    AResetHN = 1'b1;
    push_cores_ready();
    tick(1);
    chk("rst_first_edge", 64'(ATest), 64'h01);
    wait_last_run("boot_after_rst", 40);
    tick(1);
    chk("rst_ready", 64'(AReady), 64'd1);

    tick(2);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
